uart_rx_sampler: RTL and testbench

- UART receive stage downstream of the clock-divider/baud-timing logic in the UART FPGA design.
- Takes the asynchronous serial line, synchronises it, and recovers 8N1 frames by mid-bit sampling with an internal bit-period counter.
- Runs entirely in the system clock domain; there is no derived clock.
- Delivers each byte with a one-cycle valid strobe to the downstream consumer, such as a FIFO or command parser.

---
 rtl/uart_rx_sampler_if.sv | 22 ++
 rtl/uart_rx_sampler.sv | 142 ++++++++++++++
 tb/tb_uart_rx_sampler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sampler_if.sv
// Receive-side byte interface of the UART: a byte with a one-cycle valid
// strobe, a framing-error strobe and a busy flag.
interface uart_rx_sampler_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_frame_err,
        output rx_busy
    );

    modport slave (
        input rx_data,
        input rx_valid,
        input rx_frame_err,
        input rx_busy
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling driven by an
// internal bit-period counter, one-cycle valid / framing-error strobes.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               rx_in,
    uart_rx_sampler_if.master  rx_if
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;

    logic             sync1_q, sync1_d;
    logic             rxs_q, rxs_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;

    always_comb begin
        sync1_d     = rx_in;
        rxs_d       = sync1_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rxs_q) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end

            // A start bit that is high again at mid-bit is treated as a glitch.
            ST_START: begin
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        state_d = ST_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs_q;
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Leaving at mid-stop lets a start bit right after the stop bit be caught.
            ST_STOP: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // A break or stuck-low line must not decode as a stream of 0x00 bytes.
            ST_WAIT_HIGH: begin
                if (rxs_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            rxs_q       <= rxs_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rx_if.rx_data      = data_q;
    assign rx_if.rx_valid     = valid_q;
    assign rx_if.rx_frame_err = frame_err_q;
    assign rx_if.rx_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: serialised frames against an event-level model
// (expected byte / framing error and the cycle it should appear).
module tb_uart_rx_sampler;

    localparam int CPB = 16;
    // Falling edge driven at a negedge with cycle stamp k -> strobe seen at k + LAT.
    localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_in = 1'b1;

    uart_rx_sampler_if rx_if ();

    uart_rx_sampler #(.CLKS_PER_BIT(CPB)) dut (
        .clk_in (clk),
        .rst    (rst),
        .rx_in  (rx_in),
        .rx_if  (rx_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t;
        bit         err;
        logic [7:0] d;
    } ev_t;

    ev_t        got_q[$];
    ev_t        exp_q[$];
    logic [7:0] model_data = 8'h00;
    bit         prev_pulse = 1'b0;
    int         n_chk = 0;
    int         n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rx_if.rx_valid || rx_if.rx_frame_err) begin
            check_eq("pulse_exclusive", {31'd0, rx_if.rx_valid & rx_if.rx_frame_err}, 32'd0);
            check_eq("pulse_single_cycle", {31'd0, prev_pulse}, 32'd0);
            got_q.push_back('{t: cyc, err: rx_if.rx_frame_err, d: rx_if.rx_data});
        end
        prev_pulse = rx_if.rx_valid || rx_if.rx_frame_err;
    end

    task automatic hold(input logic b, input int n);
        rx_in = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        hold(1'b1, n);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        ev_t e;
        e.t   = cyc + LAT;
        e.err = !stop;
        e.d   = stop ? b : model_data;
        exp_q.push_back(e);
        if (stop) model_data = b;
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(b[i], CPB);
        hold(stop, CPB);
    endtask

    task automatic score(input string tag);
        int dt;
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            dt = got_q[i].t - exp_q[i].t;
            check_eq({tag, "_kind"}, {31'd0, got_q[i].err}, {31'd0, exp_q[i].err});
            check_eq({tag, "_data"}, {24'd0, got_q[i].d}, {24'd0, exp_q[i].d});
            check_eq({tag, "_time_within_1"}, {31'd0, (dt >= -1 && dt <= 1)}, 32'd1);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] b;
        logic       stop;
        int         gap;
        int         len;

        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        check_eq("reset_data", {24'd0, rx_if.rx_data}, 32'h00);
        check_eq("reset_valid", {31'd0, rx_if.rx_valid}, 32'd0);
        check_eq("reset_ferr", {31'd0, rx_if.rx_frame_err}, 32'd0);
        check_eq("reset_busy", {31'd0, rx_if.rx_busy}, 32'd0);
        rst = 1'b0;

        idle(100);
        check_eq("idle_busy", {31'd0, rx_if.rx_busy}, 32'd0);
        check_eq("idle_data", {24'd0, rx_if.rx_data}, 32'h00);
        score("idle");

        send_frame(8'h55, 1'b1);
        idle(20);
        check_eq("f55_data", {24'd0, rx_if.rx_data}, 32'h55);
        score("f55");

        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        idle(20);
        check_eq("b2b_gap", (got_q.size() >= 2) ? got_q[1].t - got_q[0].t : -1, 32'd160);
        score("b2b");
        check_eq("b2b_data", {24'd0, rx_if.rx_data}, 32'h0F);

        for (int i = 0; i < 4; i++) begin
            len = (i == 0) ? 4 : $urandom_range(1, 6);
            hold(1'b0, len);
            idle(30);
            check_eq("glitch_busy", {31'd0, rx_if.rx_busy}, 32'd0);
        end
        score("glitch");
        check_eq("glitch_data", {24'd0, rx_if.rx_data}, {24'd0, model_data});

        send_frame(8'h3C, 1'b0);
        hold(1'b0, 400 - CPB);
        check_eq("break_busy", {31'd0, rx_if.rx_busy}, 32'd1);
        check_eq("break_data", {24'd0, rx_if.rx_data}, 32'h0F);
        idle(5);
        check_eq("break_release_busy", {31'd0, rx_if.rx_busy}, 32'd0);
        score("break");
        send_frame(8'h81, 1'b1);
        idle(20);
        score("f81");
        check_eq("f81_data", {24'd0, rx_if.rx_data}, 32'h81);

        for (int i = 0; i < 12; i++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop);
            gap = stop ? $urandom_range(0, 12) : $urandom_range(4, 12);
            if (gap > 0) idle(gap);
        end
        idle(20);
        score("random");
        check_eq("random_data", {24'd0, rx_if.rx_data}, {24'd0, model_data});

        b = 8'h5A;
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(b[i], CPB);
        hold(b[4], CPB / 2);
        rst   = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        model_data = 8'h00;
        check_eq("rst_mid_data", {24'd0, rx_if.rx_data}, 32'h00);
        check_eq("rst_mid_busy", {31'd0, rx_if.rx_busy}, 32'd0);
        idle(200);
        score("rst_mid");
        send_frame(8'hFF, 1'b1);
        idle(20);
        score("after_rst");
        check_eq("after_rst_data", {24'd0, rx_if.rx_data}, 32'hFF);

        rx_in = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        model_data = 8'h00;
        exp_q.push_back('{t: cyc + LAT, err: 1'b1, d: 8'h00});
        hold(1'b0, 400);
        check_eq("rst_low_busy", {31'd0, rx_if.rx_busy}, 32'd1);
        idle(10);
        check_eq("rst_low_release_busy", {31'd0, rx_if.rx_busy}, 32'd0);
        score("rst_low");

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
